// File: rtl/kamacore_lsu.sv
// RV32I load/store unit: one transaction at a time, byte-lane steering for stores,
// sign/zero extension for loads, and early rejection of misaligned or unknown widths.
module kamacore_lsu #(
    parameter int CPU_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 core_valid,
    output logic                 core_ready,
    input  logic                 core_is_store,
    input  logic [2:0]           core_funct3,
    input  logic [CPU_WIDTH-1:0] core_addr,
    input  logic [CPU_WIDTH-1:0] core_wdata,
    output logic                 core_rsp_valid,
    output logic [CPU_WIDTH-1:0] core_rsp_data,
    output logic                 core_rsp_error,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic                 mem_we,
    output logic [CPU_WIDTH-1:0] mem_addr,
    output logic [3:0]           mem_wstrb,
    output logic [CPU_WIDTH-1:0] mem_wdata,
    input  logic                 mem_rsp_valid,
    input  logic [CPU_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, RESP} state_t;

    state_t               state;
    logic                 is_store_reg;
    logic [2:0]           funct3_reg;
    logic [1:0]           offset_reg;

    logic                 legal;
    logic [3:0]           st_strb;
    logic [CPU_WIDTH-1:0] st_wdata;
    logic [CPU_WIDTH-1:0] load_data;
    logic [7:0]           rbyte [4];
    logic [15:0]          rhalf;
    logic [7:0]           rsel;

    always_comb begin
        legal = 1'b0;
        case (core_funct3)
            3'b000:  legal = 1'b1;
            3'b001:  legal = ~core_addr[0];
            3'b010:  legal = (core_addr[1:0] == 2'b00);
            3'b100:  legal = ~core_is_store;
            3'b101:  legal = ~core_is_store & ~core_addr[0];
            default: legal = 1'b0;
        endcase
    end

    // Narrow stores replicate the datum across lanes; the strobe picks the lane.
    always_comb begin
        st_strb  = 4'b1111;
        st_wdata = core_wdata;
        case (core_funct3[1:0])
            2'b00: begin
                st_strb  = 4'b0001 << core_addr[1:0];
                st_wdata = {4{core_wdata[7:0]}};
            end
            2'b01: begin
                st_strb  = core_addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{core_wdata[15:0]}};
            end
            default: begin
                st_strb  = 4'b1111;
                st_wdata = core_wdata;
            end
        endcase
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_rbyte
        assign rbyte[gi] = mem_rdata[8*gi +: 8];
    end

    assign rsel  = rbyte[offset_reg];
    assign rhalf = offset_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        load_data = '0;
        case (funct3_reg)
            3'b000:  load_data = {{(CPU_WIDTH-8){rsel[7]}}, rsel};
            3'b100:  load_data = {{(CPU_WIDTH-8){1'b0}}, rsel};
            3'b001:  load_data = {{(CPU_WIDTH-16){rhalf[15]}}, rhalf};
            3'b101:  load_data = {{(CPU_WIDTH-16){1'b0}}, rhalf};
            3'b010:  load_data = mem_rdata;
            default: load_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            is_store_reg   <= 1'b0;
            funct3_reg     <= 3'b000;
            offset_reg     <= 2'b00;
            core_ready     <= 1'b1;
            core_rsp_valid <= 1'b0;
            core_rsp_data  <= '0;
            core_rsp_error <= 1'b0;
            mem_req_valid  <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wstrb      <= 4'b0000;
            mem_wdata      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (core_valid) begin
                        is_store_reg <= core_is_store;
                        funct3_reg   <= core_funct3;
                        offset_reg   <= core_addr[1:0];
                        core_ready   <= 1'b0;
                        if (legal) begin
                            state         <= REQ;
                            mem_req_valid <= 1'b1;
                            mem_we        <= core_is_store;
                            mem_addr      <= {core_addr[CPU_WIDTH-1:2], 2'b00};
                            mem_wstrb     <= core_is_store ? st_strb : 4'b0000;
                            mem_wdata     <= core_is_store ? st_wdata : '0;
                        end else begin
                            state          <= RESP;
                            core_rsp_valid <= 1'b1;
                            core_rsp_data  <= '0;
                            core_rsp_error <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    // Any mem_rsp_valid seen here belongs to nobody and is dropped.
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        mem_we        <= 1'b0;
                        mem_addr      <= '0;
                        mem_wstrb     <= 4'b0000;
                        mem_wdata     <= '0;
                        if (is_store_reg) begin
                            state          <= RESP;
                            core_rsp_valid <= 1'b1;
                            core_rsp_data  <= '0;
                            core_rsp_error <= 1'b0;
                        end else begin
                            state <= WAIT_RSP;
                        end
                    end
                end
                WAIT_RSP: begin
                    if (mem_rsp_valid) begin
                        state          <= RESP;
                        core_rsp_valid <= 1'b1;
                        core_rsp_data  <= load_data;
                        core_rsp_error <= 1'b0;
                    end
                end
                RESP: begin
                    state          <= IDLE;
                    core_ready     <= 1'b1;
                    core_rsp_valid <= 1'b0;
                    core_rsp_data  <= '0;
                    core_rsp_error <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    core_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kamacore_lsu.sv
// Randomized bench for kamacore_lsu: each transaction is predicted by an arithmetic
// model of the RV32I load/store rules and checked cycle by cycle.
module tb_kamacore_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        core_valid = 1'b0;
    logic        core_ready;
    logic        core_is_store = 1'b0;
    logic [2:0]  core_funct3 = 3'b000;
    logic [31:0] core_addr = '0;
    logic [31:0] core_wdata = '0;
    logic        core_rsp_valid;
    logic [31:0] core_rsp_data;
    logic        core_rsp_error;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rdata = '0;

    int n_checks = 0;
    int n_errors = 0;

    kamacore_lsu #(.CPU_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_valid(core_valid), .core_ready(core_ready),
        .core_is_store(core_is_store), .core_funct3(core_funct3),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .core_rsp_valid(core_rsp_valid), .core_rsp_data(core_rsp_data),
        .core_rsp_error(core_rsp_error),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata), .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected behaviour from the ISA rules: access size, alignment, lane placement, extension.
    task automatic model(input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd,
                         output bit legal, output logic [31:0] maddr, output logic [3:0] strb,
                         output logic [31:0] wdata, output logic [31:0] rsp);
        int bytes;
        int off;
        logic [31:0] mask;
        logic [31:0] v;
        bit code_ok;
        code_ok = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        bytes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        off   = int'(a % 4);
        legal = code_ok && ((a % bytes) == 0);
        mask  = (bytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * bytes)) - 32'h1);
        maddr = a - (a % 4);
        strb  = st ? 4'(((1 << bytes) - 1) << off) : 4'b0000;
        if (!st)             wdata = '0;
        else if (bytes == 1) wdata = (wd & 32'hFF) * 32'h0101_0101;
        else if (bytes == 2) wdata = (wd & 32'hFFFF) * 32'h0001_0001;
        else                 wdata = wd;
        v = (rd >> (8 * off)) & mask;
        if (!f3[2] && bytes < 4 && v[8 * bytes - 1]) v = v | ~mask;
        rsp = (!legal || st) ? 32'h0 : v;
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_core_ready"}, core_ready, 1);
        chk({pfx, "_rsp_valid"}, core_rsp_valid, 0);
        chk({pfx, "_rsp_data"}, core_rsp_data, 0);
        chk({pfx, "_rsp_error"}, core_rsp_error, 0);
        chk({pfx, "_req_valid"}, mem_req_valid, 0);
        chk({pfx, "_we"}, mem_we, 0);
        chk({pfx, "_addr"}, mem_addr, 0);
        chk({pfx, "_wstrb"}, mem_wstrb, 0);
        chk({pfx, "_wdata"}, mem_wdata, 0);
    endtask

    // Called and returns at a negedge with the DUT idle.
    task automatic run_txn(input bit st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rd,
                           input int rdly, input int wdly, input bit abort);
        bit legal;
        logic [31:0] e_addr, e_wdata, e_rsp;
        logic [3:0] e_strb;
        int cyc, req_cnt, hs_cyc, exp_lat;
        bit hs, done;
        model(st, f3, a, wd, rd, legal, e_addr, e_strb, e_wdata, e_rsp);
        exp_lat = !legal ? 1 : (st ? rdly + 2 : rdly + wdly + 3);
        chk("idle_ready", core_ready, 1);
        core_valid = 1'b1; core_is_store = st; core_funct3 = f3;
        core_addr = a; core_wdata = wd;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        cyc = 0; req_cnt = 0; hs_cyc = 0; hs = 0; done = 0;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            core_valid = 1'($urandom_range(0, 1));
            core_is_store = 1'($urandom_range(0, 1));
            core_funct3 = 3'($urandom_range(0, 7));
            core_addr = $urandom; core_wdata = $urandom;
            mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = $urandom;
            if (core_rsp_valid) begin
                chk("rsp_latency", cyc, exp_lat);
                chk("rsp_data", core_rsp_data, e_rsp);
                chk("rsp_error", core_rsp_error, {31'b0, !legal});
                core_valid = 1'b0;
                done = 1;
            end else begin
                chk("busy_ready", core_ready, 0);
                if (mem_req_valid) begin
                    if (!legal) chk("illegal_no_bus", mem_req_valid, 0);
                    chk("req_addr", mem_addr, e_addr);
                    chk("req_we", mem_we, {31'b0, st});
                    chk("req_wstrb", mem_wstrb, e_strb);
                    chk("req_wdata", mem_wdata, e_wdata);
                    if (req_cnt >= rdly) begin
                        mem_req_ready = 1'b1;
                        hs = 1; hs_cyc = cyc;
                        // Response coinciding with the handshake must be ignored.
                        if (!st) mem_rsp_valid = 1'($urandom_range(0, 1));
                    end
                    req_cnt++;
                end else if (hs && !st) begin
                    if (abort) begin
                        rst_n = 1'b0;
                        #1;
                        chk_reset_outputs("abort");
                        mem_rsp_valid = 1'b1; mem_rdata = rd;
                        core_valid = 1'b0;
                        @(negedge clk);
                        rst_n = 1'b1;
                        for (int i = 0; i < 3; i++) begin
                            @(negedge clk);
                            mem_rsp_valid = 1'b0;
                            chk("late_rsp_ignored", core_rsp_valid, 0);
                            chk("late_rsp_no_bus", mem_req_valid, 0);
                            chk("late_rsp_ready", core_ready, 1);
                        end
                        return;
                    end
                    if (cyc - hs_cyc - 1 >= wdly) begin
                        mem_rsp_valid = 1'b1;
                        mem_rdata = rd;
                    end
                end
            end
        end
        if (!done) chk("rsp_timeout", cyc, exp_lat);
        core_valid = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("pulse_once", core_rsp_valid, 0);
        chk("rsp_data_clear", core_rsp_data, 0);
        chk("rsp_error_clear", core_rsp_error, 0);
        chk("ready_back", core_ready, 1);
        $display("txn st=%0d f3=%0d addr=%h wd=%h rd=%h rdly=%0d wdly=%0d legal=%0d exp_rsp=%h",
                 st, f3, a, wd, rd, rdly, wdly, legal, e_rsp);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run_txn(1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 32'h0, 0, 0, 0);
        run_txn(0, 3'b000, 32'h0000_2001, 32'h0, 32'h1234_F678, 0, 0, 0);
        run_txn(0, 3'b100, 32'h0000_2001, 32'h0, 32'h1234_F678, 0, 1, 0);
        run_txn(0, 3'b001, 32'h0000_2002, 32'h0, 32'h8001_FFFF, 1, 0, 0);
        run_txn(0, 3'b101, 32'h0000_2002, 32'h0, 32'h8001_FFFF, 0, 2, 0);
        run_txn(0, 3'b010, 32'h0000_3002, 32'h0, 32'h0, 0, 0, 0);
        run_txn(1, 3'b010, 32'h0000_4000, 32'hDEAD_BEEF, 32'h0, 3, 0, 0);
        run_txn(1, 3'b100, 32'h0000_4000, 32'h1111_2222, 32'h0, 0, 0, 0);
        run_txn(1, 3'b001, 32'h0000_4003, 32'h1111_2222, 32'h0, 0, 0, 0);
        run_txn(0, 3'b010, 32'h0000_5000, 32'h0, 32'hCAFE_F00D, 0, 3, 1);
        run_txn(0, 3'b010, 32'h0000_5004, 32'h0, 32'hCAFE_F00D, 0, 0, 0);

        for (int n = 0; n < 150; n++) begin
            bit st;
            logic [2:0] f3;
            st = 1'($urandom_range(0, 1));
            f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                 : (st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5)));
            run_txn(st, f3, $urandom, $urandom, $urandom,
                    $urandom_range(0, 3), $urandom_range(0, 3), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/kamacore_lsu.md
KAMACORE_LSU -- requirements
Module: kamacore_lsu

Interface
REQ-001 SHALL have parameter: CPU_WIDTH, default 32, data/address width; only 32 is supported.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: core_valid  input  1  core presents a load/store.
REQ-005 SHALL have port: core_ready  output  1  LSU can accept; high only in IDLE.
REQ-006 SHALL have port: core_is_store  input  1  1 = store, 0 = load.
REQ-007 SHALL have port: core_funct3  input  3  RV32I width/sign code (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010).
REQ-008 SHALL have port: core_addr  input  CPU_WIDTH  byte address, the ALU-computed effective address.
REQ-009 SHALL have port: core_wdata  input  CPU_WIDTH  store data, LSB-aligned.
REQ-010 SHALL have port: core_rsp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port: core_rsp_data  output  CPU_WIDTH  load result, extended; 0 for stores/errors.
REQ-012 SHALL have port: core_rsp_error  output  1  misaligned or illegal funct3; qualified by core_rsp_valid.
REQ-013 SHALL have port: mem_req_valid  output  1  bus request valid.
REQ-014 SHALL have port: mem_req_ready  input  1  bus accepts request.
REQ-015 SHALL have port: mem_we  output  1  1 = write.
REQ-016 SHALL have port: mem_addr  output  CPU_WIDTH  word-aligned address (bits [1:0] = 0).
REQ-017 SHALL have port: mem_wstrb  output  4  byte-lane write enables.
REQ-018 SHALL have port: mem_wdata  output  CPU_WIDTH  lane-shifted write data.
REQ-019 SHALL have port: mem_rsp_valid  input  1  read data valid (one cycle per load).
REQ-020 SHALL have port: mem_rdata  input  CPU_WIDTH  read word.

Function
REQ-021 SHALL implement FSM states IDLE, REQ, WAIT_RSP, RESP.
REQ-022 SHALL accept a request on the cycle core_valid && core_ready, registering is_store, funct3, addr, and wdata.
REQ-023 SHALL check legality at accept: LH/LHU/SH need addr[0]=0, LW/SW need addr[1:0]=0, and funct3 must be a listed code; an illegal request goes IDLE->RESP with error=1 and no bus activity.
REQ-024 SHALL go IDLE->REQ for a legal request and hold mem_req_valid plus all mem_* outputs stable in REQ until mem_req_ready.
REQ-025 SHALL, on the REQ handshake, go to RESP for a store and to WAIT_RSP for a load.
REQ-026 SHALL, in WAIT_RSP, capture mem_rdata on mem_rsp_valid and go to RESP; mem_rsp_valid in the same cycle as the REQ handshake SHALL be ignored.
REQ-027 SHALL, in RESP, assert core_rsp_valid for exactly one cycle, then return to IDLE; core_rsp_data/error SHALL hold the final value only in that cycle and be 0 otherwise.
REQ-028 SHALL drive store lanes as follows: SB strb = 1<<addr[1:0], data byte replicated to all four lanes; SH strb = 0011 or 1100 by addr[1], halfword replicated; SW strb = 1111.
REQ-029 SHALL set mem_wstrb = 0000 for loads.
REQ-030 SHALL extract loads by addr[1:0]/addr[1]: LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word.
REQ-031 SHALL give minimum latency from accept to core_rsp_valid as follows: store 2 cycles (REQ handshake in first), load 3 cycles (rsp one cycle after handshake); error 1 cycle.
REQ-032 SHALL support only one outstanding transaction; core_valid outside IDLE SHALL be ignored.

Reset
REQ-033 SHALL, on rst_n low, immediately force state=IDLE and set core_ready=1, core_rsp_valid=0, core_rsp_data=0, core_rsp_error=0, mem_req_valid=0, mem_we=0, mem_addr=0, mem_wstrb=0, mem_wdata=0.
REQ-034 SHALL abandon an in-flight transaction on reset mid-operation with no response pulse; a late mem_rsp_valid after reset SHALL be ignored in IDLE.

Verification
REQ-035 SHALL cover SB: addr 0x1003, wdata 0x000000A5, mem_req_ready=1 -> mem_addr 0x1000, wstrb 1000, wdata 0xA5A5A5A5, rsp_valid 2 cycles after accept, error 0.
REQ-036 SHALL cover LB: addr 0x2001, mem_rdata 0x1234F678 -> rsp_data 0xFFFFFFF6; LBU at the same address -> 0x000000F6.
REQ-037 SHALL cover LH: addr 0x2002, mem_rdata 0x8001FFFF -> rsp_data 0xFFFF8001; LHU -> 0x00008001.
REQ-038 SHALL cover misaligned LW: addr 0x3002 -> rsp_valid next cycle, error 1, data 0, mem_req_valid never asserted.
REQ-039 SHALL cover backpressure: SW with mem_req_ready low for 3 cycles -> mem_* stable throughout, core_ready 0, single rsp pulse after handshake.
REQ-040 SHALL cover reset mid-load: rst_n low in WAIT_RSP -> all outputs at reset values immediately, no rsp pulse, and the next request completes normally.
